// File: rtl/adder_scheduler.sv
// rtl/adder_scheduler.sv - round-robin scheduler time-sharing one 4-bit adder slice
//
// full_adder:      4-bit combinational adder slice (a, b, cin -> sum, cout).
// adder_scheduler: arbitrates two wide add/sub requesters and ripples the
//                  operands nibble by nibble through a single slice.
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready/a/b/sub (N=0,1)  request channels
//   rsp_valid/ready/id/sum/cout       response channel
//   busy                              high whenever not IDLE

module full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*WORDS-1:0]   req0_a,
    input  logic [4*WORDS-1:0]   req0_b,
    input  logic                 req0_sub,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*WORDS-1:0]   req1_a,
    input  logic [4*WORDS-1:0]   req1_b,
    input  logic                 req1_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy
);
    localparam int W = 4 * WORDS;
    localparam logic [3:0] LAST = 4'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sub_q, sub_d;
    logic           id_q, id_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic           grant_id;
    logic           accept;
    logic [3:0]     slice_a, slice_b, slice_sum;
    logic           slice_cin, slice_cout;
    logic [5:0]     nib_base;

    // Priority pointer only breaks ties; a lone requester always wins.
    assign grant_id   = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~grant_id;
    assign req1_ready = ~rst & (state_q == IDLE) & req1_valid & grant_id;
    assign accept     = req0_ready | req1_ready;

    assign nib_base  = {cnt_q, 2'b00};
    assign slice_a   = a_q[nib_base +: 4];
    assign slice_b   = b_q[nib_base +: 4] ^ {4{sub_q}};
    // Subtract is A + ~B + 1: the +1 enters as carry-in of nibble 0.
    assign slice_cin = (cnt_q == 4'd0) ? sub_q : carry_q;

    full_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    prio_d  = ~grant_id;
                    id_d    = grant_id;
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    sub_d   = grant_id ? req1_sub : req0_sub;
                    cnt_d   = 4'd0;
                end
            end
            CALC: begin
                sum_d[nib_base +: 4] = slice_sum;
                carry_d              = slice_cout;
                if (cnt_q == LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= 4'd0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_adder_scheduler.sv
// tb/tb_adder_scheduler.sv - directed self-checking bench for adder_scheduler
module tb_adder_scheduler;
    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_scheduler #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Single request from one requester; checks ready, latency and result.
    task automatic run_op(input string tag, input logic id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        #1;
        check({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
        step();                                   // accept edge T, now in T+1
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '1; req0_b = '1; req1_a = '1; req1_b = '1;  // inputs may change after accept
        check({tag, "_busy"}, busy, 1'b1);
        for (int k = 1; k < WORDS; k++) step();   // T+WORDS
        check({tag, "_early"}, rsp_valid, 1'b0);
        step();                                   // T+WORDS+1
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_sum"}, rsp_sum, exp_sum);
        check({tag, "_cout"}, rsp_cout, exp_cout);
        check({tag, "_id"}, rsp_id, id);
        step();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    int acc_cyc[8];
    int acc_id[8];
    int rsp_ids[4];
    int n_acc, n_rsp, bound;
    logic [W-1:0] hold_sum;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp_ready = 1'b1;

        // Reset state, with a requester already valid.
        step();
        step();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_sum", rsp_sum, 16'h0000);
        check("rst_rsp_cout", rsp_cout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        rst = 1'b0;
        step();

        run_op("add", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
        run_op("wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("sub_neg", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_pos", 1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);

        // Contention: both valid continuously from reset.
        do_reset();
        req0_a = 16'h1000; req0_b = 16'h0001; req0_sub = 1'b0;
        req1_a = 16'h2000; req1_b = 16'h0003; req1_sub = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 60 && n_rsp < 4; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                check("cont_rdy_idle", busy, 1'b0);
                check("cont_rdy_onehot", req0_ready & req1_ready, 1'b0);
                if (n_acc < 8) begin
                    acc_cyc[n_acc] = i;
                    acc_id[n_acc]  = req1_ready ? 1 : 0;
                end
                n_acc++;
            end
            if (rsp_valid) begin
                if (n_rsp < 4) rsp_ids[n_rsp] = rsp_id ? 1 : 0;
                check("cont_sum", rsp_sum, rsp_id ? 16'h1FFD : 16'h1001);
                check("cont_cout", rsp_cout, rsp_id ? 1'b1 : 1'b0);
                n_rsp++;
            end
            @(posedge clk);
        end
        #1;
        check("cont_n_rsp", n_rsp, 4);
        check("cont_n_acc", n_acc, 4);
        for (int j = 0; j < 4; j++) begin
            check("cont_acc_id", acc_id[j], j % 2);
            check("cont_rsp_id", rsp_ids[j], j % 2);
        end
        for (int j = 1; j < 4; j++) check("cont_spacing", acc_cyc[j] - acc_cyc[j-1], 6);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure with requester 1 pending throughout.
        do_reset();
        rsp_ready  = 1'b0;
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_sub = 1'b0;
        req1_a = 16'h0001; req1_b = 16'h0001; req1_sub = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("bp_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        bound = 0;
        while (!rsp_valid && bound < 20) begin
            step();
            bound++;
        end
        check("bp_reached_done", rsp_valid, 1'b1);
        check("bp_sum", rsp_sum, 16'h0100);
        hold_sum = rsp_sum;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", rsp_valid, 1'b1);
            check("bp_hold_sum", rsp_sum, hold_sum);
            check("bp_hold_id", rsp_id, 1'b0);
            check("bp_hold_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_release_idle", busy, 1'b0);
        check("bp_pending_granted", req1_ready, 1'b1);
        req1_valid = 1'b0;                       // withdraw before grant edge
        step();
        check("bp_withdrawn", busy, 1'b0);

        // Reset in the second CALC cycle aborts the operation.
        do_reset();
        req0_a = 16'h0101; req0_b = 16'h0101; req0_sub = 1'b0;
        req0_valid = 1'b1;
        step();                                  // accept; CALC cycle 0
        req0_valid = 1'b0;
        step();                                  // CALC cycle 1
        rst = 1'b1;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_valid", rsp_valid, 1'b0);
        check("abort_sum", rsp_sum, 16'h0000);
        rst = 1'b0;
        bound = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) bound++;
        end
        check("abort_no_rsp", bound, 0);
        req1_a = 16'h0F0F; req1_b = 16'h0101; req1_sub = 1'b0;
        req1_valid = 1'b1;
        req0_valid = 1'b1;
        #1;
        check("abort_prio_r1", req1_ready, 1'b0);
        req1_valid = 1'b0;
        run_op("after_abort", 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
